// File: rtl/givens_pkg.sv
// Shared types, constants and FP32 arithmetic helpers for the Givens rotation path.
// fp_mul / fp_add: round-to-nearest-even, subnormal inputs and results flush to
// signed zero, NaN operands are returned unmodified, Inf propagates.
package givens_pkg;

  typedef logic [31:0] fp32_t;
  typedef fp32_t [0:3][0:3] mat4_t;

  typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} rot_state_t;

  localparam int    FP_SIGN_BIT = 31;
  localparam fp32_t FP_ZERO     = 32'h0;
  localparam fp32_t FP_QNAN     = 32'h7FC0_0000;

  function automatic logic fp_is_nan(input fp32_t a);
    return (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
  endfunction

  // Sign flip only; the magnitude bits are untouched.
  function automatic fp32_t fp_neg(input fp32_t a);
    fp32_t r;
    r = a;
    r[FP_SIGN_BIT] = ~a[FP_SIGN_BIT];
    return r;
  endfunction

  function automatic fp32_t fp_mul(input fp32_t a, input fp32_t b);
    logic              sr;
    logic [7:0]        ea, eb;
    logic [47:0]       p;
    logic signed [9:0] e;
    logic [24:0]       m;
    logic              g, st;
    fp32_t             r;
    sr = a[31] ^ b[31];
    ea = a[30:23];
    eb = b[30:23];
    p  = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    if (p[47]) begin
      m  = {1'b0, p[47:24]};
      g  = p[23];
      st = |p[22:0];
      e  = e + 10'sd1;
    end else begin
      m  = {1'b0, p[46:23]};
      g  = p[22];
      st = |p[21:0];
    end
    if (g && (st || m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e = e + 10'sd1;
    end
    if (fp_is_nan(a))                  r = a;
    else if (fp_is_nan(b))             r = b;
    else if (ea == 8'hFF || eb == 8'hFF)
      r = (ea == 8'h00 || eb == 8'h00) ? FP_QNAN : {sr, 8'hFF, 23'h0};
    else if (ea == 8'h00 || eb == 8'h00) r = {sr, 31'h0};
    else if (e >= 10'sd255)            r = {sr, 8'hFF, 23'h0};
    else if (e <= 10'sd0)              r = {sr, 31'h0};
    else                               r = {sr, e[7:0], 23'(m)};
    return r;
  endfunction

  function automatic fp32_t fp_add(input fp32_t a, input fp32_t b);
    fp32_t             x, y, r;
    logic [7:0]        ea, eb, d;
    logic [26:0]       mx, my;
    logic [53:0]       sh;
    logic [27:0]       sum;
    logic signed [9:0] e;
    logic [24:0]       m;
    logic              g, st;
    ea = a[30:23];
    eb = b[30:23];
    // Larger magnitude goes to x so the alignment shift is always non-negative.
    if (a[30:0] >= b[30:0]) begin
      x = a; y = b;
    end else begin
      x = b; y = a;
    end
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    d  = x[30:23] - y[30:23];
    sh = 54'h0;
    if (d > 8'd26) begin
      my = 27'd1;
    end else begin
      sh = {my, 27'h0} >> d;
      my = sh[53:27] | {26'h0, |sh[26:0]};
    end
    e = $signed({2'b00, x[30:23]});
    if (x[31] == y[31]) begin
      sum = {1'b0, mx} + {1'b0, my};
      if (sum[27]) begin
        sum = {1'b0, sum[27:2], sum[1] | sum[0]};
        e   = e + 10'sd1;
      end
    end else begin
      sum = {1'b0, mx} - {1'b0, my};
      for (int k = 0; k < 26; k++) begin
        if (!sum[26] && sum != 28'h0) begin
          sum = sum << 1;
          e   = e - 10'sd1;
        end
      end
    end
    m  = {1'b0, sum[26:3]};
    g  = sum[2];
    st = |sum[1:0];
    if (g && (st || m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e = e + 10'sd1;
    end
    if (fp_is_nan(a))                    r = a;
    else if (fp_is_nan(b))               r = b;
    else if (ea == 8'hFF && eb == 8'hFF) r = (a[31] != b[31]) ? FP_QNAN : a;
    else if (ea == 8'hFF)                r = a;
    else if (eb == 8'hFF)                r = b;
    else if (ea == 8'h00 && eb == 8'h00) r = {a[31] & b[31], 31'h0};
    else if (ea == 8'h00)                r = b;
    else if (eb == 8'h00)                r = a;
    else if (sum == 28'h0)               r = FP_ZERO;
    else if (e >= 10'sd255)              r = {x[31], 8'hFF, 23'h0};
    else if (e <= 10'sd0)                r = {x[31], 31'h0};
    else                                 r = {x[31], e[7:0], 23'(m)};
    return r;
  endfunction

endpackage

// File: rtl/givens_pair_mac.sv
// One column of the 2x2 Givens rotate: four products registered on mul_en,
// then two combinational sums read by the parent during its ADD cycle.
module givens_pair_mac
  import givens_pkg::*;
(
  input  logic  clk,
  input  logic  mul_en,
  input  fp32_t c,
  input  fp32_t s,
  input  fp32_t a_i,
  input  fp32_t a_j,
  output fp32_t w_i,
  output fp32_t w_j
);

  fp32_t ci_p1_d, sj_p1_d, si_p1_d, cj_p1_d;
  fp32_t ci_p1_q, sj_p1_q, si_p1_q, cj_p1_q;

  // Product stage: compute all four products, hold them outside MUL.
  always_comb begin
    ci_p1_d = ci_p1_q;
    sj_p1_d = sj_p1_q;
    si_p1_d = si_p1_q;
    cj_p1_d = cj_p1_q;
    if (mul_en) begin
      ci_p1_d = fp_mul(c, a_i);
      sj_p1_d = fp_mul(s, a_j);
      si_p1_d = fp_mul(s, a_i);
      cj_p1_d = fp_mul(c, a_j);
    end
  end

  // Product register (data only, no reset).
  always_ff @(posedge clk) begin
    ci_p1_q <= ci_p1_d;
    sj_p1_q <= sj_p1_d;
    si_p1_q <= si_p1_d;
    cj_p1_q <= cj_p1_d;
  end

  // Sum stage: (-s)*a_j is the registered s*a_j with its sign bit flipped.
  always_comb begin
    w_i = fp_add(ci_p1_q, fp_neg(sj_p1_q));
    w_j = fp_add(si_p1_q, cj_p1_q);
  end

endmodule

// File: rtl/givens_row_rotate.sv
// Applies a Givens rotation (c, s, i, j) to a 4x4 FP32 matrix, updating only
// rows i and j one column at a time (MUL then ADD per column).
// Optional build macro GIVENS_ZERO_FORCE_EN: writes the annihilated element
// W[j][i] as exact +0 instead of the computed residue.
module givens_row_rotate
  import givens_pkg::*;
#(
  parameter int DW = 32,
  parameter int N  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  mat4_t         a_in,
  input  logic [DW-1:0] c,
  input  logic [DW-1:0] s,
  input  logic [1:0]    i,
  input  logic [1:0]    j,
  output logic          out_valid,
  input  logic          out_ready,
  output mat4_t         a_out,
  output logic          busy
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_COL = CW'(N - 1);

`ifdef GIVENS_ZERO_FORCE_EN
  localparam bit ZERO_FORCE = 1'b1;
`else
  localparam bit ZERO_FORCE = 1'b0;
`endif

  rot_state_t    state_d, state_q;
  logic [CW-1:0] col_d, col_q;
  mat4_t         a_out_d, a_out_q;
  mat4_t         work_d, work_q;
  fp32_t         c_d, c_q, s_d, s_q;
  logic [1:0]    i_d, i_q, j_d, j_q;
  fp32_t         w_i, w_j;

  givens_pair_mac u_mac (
    .clk    (clk),
    .mul_en (state_q == MUL),
    .c      (c_q),
    .s      (s_q),
    .a_i    (work_q[i_q][col_q]),
    .a_j    (work_q[j_q][col_q]),
    .w_i    (w_i),
    .w_j    (w_j)
  );

  // Next-state, working-matrix update and result load.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    a_out_d = a_out_q;
    work_d  = work_q;
    c_d     = c_q;
    s_d     = s_q;
    i_d     = i_q;
    j_d     = j_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d = a_in;
          c_d    = c;
          s_d    = s;
          i_d    = i;
          j_d    = j;
          col_d  = '0;
          // Identity rotation on a single row: publish the input directly.
          if (i == j) begin
            a_out_d = a_in;
            state_d = DONE;
          end else begin
            state_d = MUL;
          end
        end
      end
      MUL: state_d = ADD;
      ADD: begin
        // The column being written was already consumed by the preceding MUL.
        work_d[i_q][col_q] = w_i;
        work_d[j_q][col_q] = w_j;
        if (ZERO_FORCE && (col_q == i_q)) work_d[j_q][col_q] = FP_ZERO;
        if (col_q == LAST_COL) begin
          a_out_d = work_d;
          state_d = DONE;
        end else begin
          col_d   = col_q + 1'b1;
          state_d = MUL;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers, synchronously reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      a_out_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      a_out_q <= a_out_d;
    end
  end

  // Working operands (data only, no reset).
  always_ff @(posedge clk) begin
    work_q <= work_d;
    c_q    <= c_d;
    s_q    <= s_d;
    i_q    <= i_d;
    j_q    <= j_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign a_out     = a_out_q;

endmodule
